// File: rtl/clock_pkg.sv
// Shared constants and state type for the time-of-day up-counters and the countdown timer.
package clock_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/preset inputs and time/status outputs of the countdown timer.
interface countdown_timer_if;
    import clock_pkg::*;

    logic              tick;
    logic              load;
    logic [HOUR_W-1:0] load_hour;
    logic [MIN_W-1:0]  load_min;
    logic [SEC_W-1:0]  load_sec;
    logic              start;
    logic              stop;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic              running;
    logic              expired;
    logic              done;

    modport master (
        output tick, load, load_hour, load_min, load_sec, start, stop,
        input  hour, min, sec, running, expired, done
    );

    modport slave (
        input  tick, load, load_hour, load_min, load_sec, start, stop,
        output hour, min, sec, running, expired, done
    );

endinterface

// File: rtl/down_counter_mod.sv
// One field of the borrow chain: decrements on dec, wraps 0 -> MAX and flags the borrow.
module down_counter_mod #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] q,
    output logic         borrow_out
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (dec) begin
            q_d = (q_q == '0) ? W'(MAX) : q_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign borrow_out = dec && (q_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// hh:mm:ss countdown timer: control FSM, preset clamping, expiry detect and done pulse.
module countdown_timer
    import clock_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);

    state_e state_q, state_d;
    logic   running_q, expired_q, done_q, done_d;

    logic [HOUR_W-1:0] hour_q, load_hour_c;
    logic [MIN_W-1:0]  min_q, load_min_c;
    logic [SEC_W-1:0]  sec_q, load_sec_c;
    logic              sec_borrow, min_borrow, hour_borrow_unused;
    logic              tick_en, value_zero, zero_next;

    assign load_hour_c = (bus.load_hour > HOUR_W'(HOUR_MAX)) ? HOUR_W'(HOUR_MAX) : bus.load_hour;
    assign load_min_c  = (bus.load_min  > MIN_W'(MIN_MAX))   ? MIN_W'(MIN_MAX)   : bus.load_min;
    assign load_sec_c  = (bus.load_sec  > SEC_W'(SEC_MAX))   ? SEC_W'(SEC_MAX)   : bus.load_sec;

    // load and stop both pre-empt a tick; start has no effect in RUN, so it does not.
    assign tick_en    = (state_q == RUN) && bus.tick && !bus.load && !bus.stop;
    assign value_zero = (hour_q == '0) && (min_q == '0) && (sec_q == '0);
    assign zero_next  = tick_en && (hour_q == '0) && (min_q == '0) && (sec_q == SEC_W'(1));

    down_counter_mod #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .load(bus.load), .load_val(load_sec_c),
        .dec(tick_en), .q(sec_q), .borrow_out(sec_borrow)
    );

    down_counter_mod #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .load(bus.load), .load_val(load_min_c),
        .dec(sec_borrow), .q(min_q), .borrow_out(min_borrow)
    );

    // RUN is left at zero, so the hour field never borrows.
    down_counter_mod #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .load(bus.load), .load_val(load_hour_c),
        .dec(min_borrow), .q(hour_q), .borrow_out(hour_borrow_unused)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (bus.load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (!bus.stop && bus.start && !value_zero) state_d = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (zero_next) begin
                        state_d = EXPIRED;
                        done_d  = 1'b1;
                    end
                end
                EXPIRED: begin
                    if (bus.stop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
            expired_q <= (state_d == EXPIRED);
            done_q    <= done_d;
        end
    end

    assign bus.hour    = hour_q;
    assign bus.min     = min_q;
    assign bus.sec     = sec_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Countdown timer bench: directed scenarios with literal expectations plus random traffic against a seconds-total model.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    countdown_timer_if bus();

    countdown_timer u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: remaining time as a plain seconds total plus a mode word.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    typedef struct {
        int t;
        int mode;
        bit done;
    } model_t;

    model_t mdl = '{t: 0, mode: M_IDLE, done: 1'b0};

    function automatic int clampi(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic model_t model_step(model_t m, bit r, bit ld, int h, int mi, int s,
                                          bit st, bit sp, bit tk);
        model_t n = m;
        n.done = 1'b0;
        if (r) begin
            n.t = 0; n.mode = M_IDLE;
        end else if (ld) begin
            n.t    = clampi(h, 23) * 3600 + clampi(mi, 59) * 60 + clampi(s, 59);
            n.mode = M_IDLE;
        end else if (sp) begin
            if (m.mode == M_RUN) n.mode = M_PAUSE;
            else if (m.mode == M_EXP) n.mode = M_IDLE;
        end else if (st && (m.mode == M_IDLE || m.mode == M_PAUSE)) begin
            if (m.t != 0) n.mode = M_RUN;
        end else if (tk && m.mode == M_RUN) begin
            n.t = m.t - 1;
            if (n.t == 0) begin
                n.mode = M_EXP;
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        mdl <= model_step(mdl, rst, bus.load, int'(bus.load_hour), int'(bus.load_min),
                          int'(bus.load_sec), bus.start, bus.stop, bus.tick);
    end

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_hour",    int'(bus.hour),    mdl.t / 3600);
            check("cyc_min",     int'(bus.min),     (mdl.t / 60) % 60);
            check("cyc_sec",     int'(bus.sec),     mdl.t % 60);
            check("cyc_running", int'(bus.running), int'(mdl.mode == M_RUN));
            check("cyc_expired", int'(bus.expired), int'(mdl.mode == M_EXP));
            check("cyc_done",    int'(bus.done),    int'(mdl.done));
        end
    end

    // Applies one cycle of inputs; returns #1 after the edge that sampled them.
    task automatic step(bit r, bit ld, int h, int mi, int s, bit st, bit sp, bit tk);
        rst           = r;
        bus.load      = ld;
        bus.load_hour = 5'(h);
        bus.load_min  = 6'(mi);
        bus.load_sec  = 6'(s);
        bus.start     = st;
        bus.stop      = sp;
        bus.tick      = tk;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_load(int h, int mi, int s);
        step(0, 1, h, mi, s, 0, 0, 0);
    endtask
    task automatic do_start();
        step(0, 0, 0, 0, 0, 1, 0, 0);
    endtask
    task automatic do_tick();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic chk_all(string name, int h, int mi, int s, int r, int e, int d);
        check({name, "_hour"},    int'(bus.hour),    h);
        check({name, "_min"},     int'(bus.min),     mi);
        check({name, "_sec"},     int'(bus.sec),     s);
        check({name, "_running"}, int'(bus.running), r);
        check({name, "_expired"}, int'(bus.expired), e);
        check({name, "_done"},    int'(bus.done),    d);
        check({name, "_model"},   mdl.t,             h * 3600 + mi * 60 + s);
    endtask

    initial begin
        bus.tick = 0; bus.load = 0; bus.start = 0; bus.stop = 0;
        bus.load_hour = 0; bus.load_min = 0; bus.load_sec = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        do_start();
        chk_all("start_zero", 0, 0, 0, 0, 0, 0);

        do_load(0, 0, 3);
        do_start();
        chk_all("run3", 0, 0, 3, 1, 0, 0);
        do_tick();  chk_all("tick2", 0, 0, 2, 1, 0, 0);
        do_tick();  chk_all("tick1", 0, 0, 1, 1, 0, 0);
        do_tick();  chk_all("expire", 0, 0, 0, 0, 1, 1);
        idle(1);    chk_all("done_fall", 0, 0, 0, 0, 1, 0);
        do_tick();
        do_tick();  chk_all("exp_hold", 0, 0, 0, 0, 1, 0);

        do_load(1, 0, 0); do_start(); do_tick();
        chk_all("borrow_hr", 0, 59, 59, 1, 0, 0);
        do_load(0, 1, 0); do_start(); do_tick();
        chk_all("borrow_min", 0, 0, 59, 1, 0, 0);

        do_load(0, 0, 10); do_start();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk_all("paused", 0, 0, 10, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_tick();
        chk_all("pause_hold", 0, 0, 10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk_all("stop_wins", 0, 0, 10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        chk_all("start_drops_tick", 0, 0, 10, 1, 0, 0);
        do_tick();
        chk_all("resume", 0, 0, 9, 1, 0, 0);

        do_load(31, 63, 60);
        chk_all("clamp", 23, 59, 59, 0, 0, 0);
        do_start();
        step(0, 1, 0, 0, 5, 0, 0, 1);
        chk_all("load_beats_tick", 0, 0, 5, 0, 0, 0);

        do_load(0, 0, 2); do_start();
        do_tick(); do_tick();
        chk_all("held_tick", 0, 0, 0, 0, 1, 1);

        do_load(0, 0, 5); do_start();
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk_all("rst_run", 0, 0, 0, 0, 0, 0);
        do_load(0, 0, 1); do_start();
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk_all("rst_cancel_done", 0, 0, 0, 0, 0, 0);

        do_load(0, 0, 1); do_start(); do_tick();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk_all("ack", 0, 0, 0, 0, 0, 0);
        do_start();
        chk_all("ack_idle_zero", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            bit r, ld, st, sp, tk;
            int h, mi, s;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 6) == 0);
            sp = ($urandom_range(0, 14) == 0);
            tk = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) begin
                h = $urandom_range(0, 31); mi = $urandom_range(0, 63); s = $urandom_range(0, 63);
            end else begin
                h = ($urandom_range(0, 9) == 0) ? 1 : 0;
                mi = $urandom_range(0, 1);
                s = $urandom_range(0, 8);
            end
            step(r, ld, h, mi, s, st, sp, tk);
        end

        idle(2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Hour/minute/second down-counter for the alarm clock's countdown and snooze functions. It is the mirror of the existing up-counting sec/min/hour chain: a per-cycle tick enable decrements a loaded hh:mm:ss value through a borrow chain instead of a carry chain. It signals expiry at 00:00:00. It sits beside the time-of-day counters, shares their tick source, and feeds the alarm/buzzer logic.

## Interface
- No parameters. Ranges are fixed: hours 0–23, minutes and seconds 0–59, binary-coded.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  count enable; each cycle it is sampled high decrements by one second
- load  in  1  load preset value, one-cycle strobe
- load_hour  in  5  preset hours
- load_min  in  6  preset minutes
- load_sec  in  6  preset seconds
- start  in  1  begin or resume counting, one-cycle strobe
- stop  in  1  pause counting, or acknowledge expiry, one-cycle strobe
- hour  out  5  current hours
- min  out  6  current minutes
- sec  out  6  current seconds
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED
- done  out  1  one-cycle pulse on expiry

## Operation
- States:
  - IDLE: value loaded or reset.
  - RUN: decrementing.
  - PAUSE: value held.
  - EXPIRED: value held at 00:00:00.
- Reset: state IDLE; hour, min and sec all 0; running, expired and done all 0.
- Input priority, highest first: rst, load, stop, start, tick.
- load, in any state:
  - Registers the preset; state becomes IDLE.
  - Out-of-range fields clamp: hour>23→23, min>59→59, sec>59→59.
  - A tick in the same cycle is dropped.
- start:
  - IDLE or PAUSE → RUN if the value is nonzero.
  - IDLE or PAUSE with a zero value: start is ignored.
  - In RUN or EXPIRED, start is ignored.
- stop:
  - RUN → PAUSE.
  - EXPIRED → IDLE; the value stays 0.
  - In IDLE or PAUSE, stop is a no-op.
  - With start in the same cycle, stop wins.
- tick:
  - Acts only in RUN; it is ignored in every other state.
  - sec>0: sec−1.
  - sec=0: sec→59 and borrow into min.
  - min borrow: min>0 → min−1; min=0 → min→59 and borrow into hour.
  - hour borrow: hour−1. The value is never decremented below 00:00:00, because RUN is left when zero is reached.
- Expiry: a RUN tick that produces 00:00:00 moves the state to EXPIRED and sets done for exactly one cycle.
- A held-high tick decrements on every clock.

## Timing
- All outputs are registered and reflect state from the previous edge. No combinational input-to-output path.
- Decrement latency is 1 cycle: tick sampled high at edge N updates hour/min/sec after edge N.
- done:
  - Rises after the same edge that makes the value zero and the state EXPIRED.
  - Falls after the next edge.
  - It asserts once per expiry, never in IDLE or PAUSE.
- running and expired are decoded registered state. They change after the edge that changes state.
- start/stop latency is 1 cycle. A start and a tick in the same cycle from PAUSE: the state becomes RUN and that tick is not counted.
- rst mid-RUN clears everything on the next edge. A pending done is cancelled.

## Structure
- Shared package `clock_pkg`:
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths 6, 6, 5.
  - State enum {IDLE, RUN, PAUSE, EXPIRED}.
  - The existing up-counters migrate to these constants.
- Sub-module `down_counter_mod`:
  - Ports: width/max parameters, clk, rst, load, load_val, dec, q, borrow_out.
  - borrow_out = dec && q==0. On a borrow, q wraps to max.
  - Instantiated three times as the sec → min → hour borrow chain.
- Top level: FSM, clamping, zero detect, done register.

## Test plan
- Reset, then idle: after rst, all outputs are 0. start with a zero value leaves running=0.
- Load 00:00:03, start, then 3 single-cycle ticks: sec goes 2, 1, 0. After the 3rd tick, expired=1 and done is high for exactly 1 cycle. Further ticks keep 00:00:00.
- Borrow chain: load 01:00:00, start, 1 tick → 00:59:59. Load 00:01:00, 1 tick → 00:00:59.
- Pause and priority:
  - RUN at 00:00:10, stop → running=0. 5 ticks leave 00:00:10.
  - start and stop in the same cycle → stays PAUSE.
  - start then tick → 00:00:09.
- Clamp and load precedence: load 31:63:60 → 23:59:59. In RUN, load and tick in the same cycle → the loaded value, state IDLE.
- Reset mid-operation and acknowledge:
  - Assert rst during RUN with tick held high → 00:00:00, IDLE, done=0.
  - Separately, stop in EXPIRED → expired=0, IDLE.
